menu_select_ctrl: RTL and testbench

- Input/control stage directly upstream of the title-screen pixel generator; runs on the 25 MHz pixel clock, same domain as the VGA timing controller.
- Debounces raw push-buttons and derives a once-per-frame tick from vsync.
- Runs the title/select/confirm/play menu state machine.
- Drives the selected block index (0 = blue, 1 = red), a highlight blink enable and game-start signals that the pixel generator and game logic consume.

---
 rtl/menu_select_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_menu_select_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : menu_select_ctrl
// Purpose  : Button debounce, vsync frame tick and title/select/confirm/play
//            menu state machine feeding the title-screen pixel generator.
// Revision : 1.0 - initial release
// ============================================================================
module menu_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_FRAMES    = 15,
    parameter int CONFIRM_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       btn_back,
    input  logic       vsync,
    output logic       sel,
    output logic       highlight,
    output logic       start_game,
    output logic       game_mode,
    output logic [1:0] state
);

    localparam int c_db_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_blk_w = (BLINK_FRAMES > 1)    ? $clog2(BLINK_FRAMES)    : 1;
    localparam int c_frm_w = (CONFIRM_FRAMES > 1)  ? $clog2(CONFIRM_FRAMES)  : 1;

    localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(BLINK_FRAMES - 1);
    localparam logic [c_frm_w-1:0] c_frm_last = c_frm_w'(CONFIRM_FRAMES - 1);

    localparam int c_btn_left  = 0;
    localparam int c_btn_right = 1;
    localparam int c_btn_enter = 2;
    localparam int c_btn_back  = 3;

    typedef enum logic [1:0] {
        ST_TITLE   = 2'd0,
        ST_SELECT  = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_PLAY    = 2'd3
    } state_t;

    logic [3:0] w_btn_raw;
    logic [3:0] w_press;

    assign w_btn_raw = {btn_back, btn_enter, btn_right, btn_left};

    // ------------------------------------------------------------------------
    // Per-button synchronizer and debouncer
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic              sync1_q, sync1_d;
        logic              sync2_q, sync2_d;
        logic              stable_q, stable_d;
        logic [c_db_w-1:0] cnt_q, cnt_d;
        logic              w_commit;

        always_comb begin
            sync1_d  = w_btn_raw[gi];
            sync2_d  = sync1_q;
            stable_d = stable_q;
            cnt_d    = '0;
            w_commit = 1'b0;
            if (sync2_q != stable_q) begin
                if (cnt_q == c_db_last) begin
                    stable_d = sync2_q;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= sync1_d;
                sync2_q  <= sync2_d;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        // Pulse coincides with the stable-level update so the FSM reacts on
        // the same edge that accepts the new level.
        assign w_press[gi] = w_commit & sync2_q;
    end

    // ------------------------------------------------------------------------
    // Frame tick on vsync falling edge
    // ------------------------------------------------------------------------
    logic vsync_q, vsync_d;
    logic w_tick;

    always_comb begin
        vsync_d = vsync;
    end

    assign w_tick = vsync_q & ~vsync;

    // ------------------------------------------------------------------------
    // Press priority: back > enter > left/right
    // ------------------------------------------------------------------------
    logic       w_back;
    logic       w_enter;
    logic [1:0] w_lr;

    assign w_back  = w_press[c_btn_back];
    assign w_enter = w_press[c_btn_enter] & ~w_press[c_btn_back];
    assign w_lr    = {w_press[c_btn_right], w_press[c_btn_left]}
                   & {2{~(w_press[c_btn_back] | w_press[c_btn_enter])}};

    // ------------------------------------------------------------------------
    // Menu state machine
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic               highlight_q, highlight_d;
    logic               start_game_q, start_game_d;
    logic               game_mode_q, game_mode_d;
    logic [c_blk_w-1:0] blink_q, blink_d;
    logic [c_frm_w-1:0] frame_q, frame_d;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        highlight_d  = highlight_q;
        start_game_d = 1'b0;
        game_mode_d  = game_mode_q;
        blink_d      = blink_q;
        frame_d      = frame_q;

        case (state_q)
            ST_TITLE: begin
                highlight_d = 1'b0;
                if (w_enter) begin
                    state_d     = ST_SELECT;
                    highlight_d = 1'b1;
                    blink_d     = '0;
                end
            end

            ST_SELECT: begin
                if (w_back) begin
                    state_d     = ST_TITLE;
                    highlight_d = 1'b0;
                end else if (w_enter) begin
                    state_d     = ST_CONFIRM;
                    highlight_d = 1'b1;
                    frame_d     = '0;
                end else begin
                    if (w_lr == 2'b01) begin
                        sel_d = 1'b0;
                    end else if (w_lr == 2'b10) begin
                        sel_d = 1'b1;
                    end
                    if (w_tick) begin
                        if (blink_q == c_blk_last) begin
                            highlight_d = ~highlight_q;
                            blink_d     = '0;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end
            end

            ST_CONFIRM: begin
                if (w_back) begin
                    state_d     = ST_SELECT;
                    highlight_d = 1'b1;
                    blink_d     = '0;
                end else if (w_tick) begin
                    if (frame_q == c_frm_last) begin
                        state_d      = ST_PLAY;
                        game_mode_d  = sel_q;
                        start_game_d = 1'b1;
                        highlight_d  = 1'b0;
                    end else begin
                        frame_d     = frame_q + 1'b1;
                        highlight_d = ~highlight_q;
                    end
                end
            end

            ST_PLAY: begin
                highlight_d = 1'b0;
                if (w_back) begin
                    state_d = ST_TITLE;
                end
            end

            default: begin
                state_d     = ST_TITLE;
                highlight_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vsync_q      <= 1'b0;
            state_q      <= ST_TITLE;
            sel_q        <= 1'b0;
            highlight_q  <= 1'b0;
            start_game_q <= 1'b0;
            game_mode_q  <= 1'b0;
            blink_q      <= '0;
            frame_q      <= '0;
        end else begin
            vsync_q      <= vsync_d;
            state_q      <= state_d;
            sel_q        <= sel_d;
            highlight_q  <= highlight_d;
            start_game_q <= start_game_d;
            game_mode_q  <= game_mode_d;
            blink_q      <= blink_d;
            frame_q      <= frame_d;
        end
    end

    assign sel        = sel_q;
    assign highlight  = highlight_q;
    assign start_game = start_game_q;
    assign game_mode  = game_mode_q;
    assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_select_ctrl
// Purpose  : Directed, table-driven self-checking bench for menu_select_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_select_ctrl;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       btn_left  = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_back  = 1'b0;
    logic       vsync     = 1'b1;
    logic       sel;
    logic       highlight;
    logic       start_game;
    logic       game_mode;
    logic [1:0] state;

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    menu_select_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_FRAMES    (2),
        .CONFIRM_FRAMES  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_enter  (btn_enter),
        .btn_back   (btn_back),
        .vsync      (vsync),
        .sel        (sel),
        .highlight  (highlight),
        .start_game (start_game),
        .game_mode  (game_mode),
        .state      (state)
    );

    always @(negedge clk) begin
        if (start_game === 1'b1) start_cnt++;
    end

    // {back, enter, right, left}
    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic [1:0] exp_state;
        logic       exp_sel;
        logic       exp_hl;
    } vec_t;

    vec_t vecs [8];
    int   exp_blink [6];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_back, btn_enter, btn_right, btn_left} = b;
    endtask

    task automatic press(input logic [3:0] b, input int hold);
        set_btn(b);
        step(hold);
        set_btn(4'b0000);
        step(12);
    endtask

    task automatic frame();
        vsync = 1'b0;
        step(2);
        vsync = 1'b1;
        step(18);
    endtask

    task automatic run_vec(input int i);
        press(vecs[i].btn, vecs[i].hold);
        chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
        chk($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
        chk($sformatf("vec%0d_hl", i), highlight, vecs[i].exp_hl);
    endtask

    initial begin
        vecs[0] = '{4'b0010, 10, 2'd0, 1'b0, 1'b0};  // right ignored in TITLE
        vecs[1] = '{4'b1000, 10, 2'd0, 1'b0, 1'b0};  // back ignored in TITLE
        vecs[2] = '{4'b0010,  3, 2'd1, 1'b0, 1'b1};  // 3-clk glitch rejected
        vecs[3] = '{4'b0010, 10, 2'd1, 1'b1, 1'b1};  // right -> red
        vecs[4] = '{4'b0010, 10, 2'd1, 1'b1, 1'b1};  // right saturates
        vecs[5] = '{4'b0001, 10, 2'd1, 1'b0, 1'b1};  // left -> blue
        vecs[6] = '{4'b0010, 10, 2'd1, 1'b1, 1'b1};  // right -> red
        vecs[7] = '{4'b0011, 10, 2'd1, 1'b1, 1'b1};  // left+right no change
        exp_blink = '{1, 0, 0, 1, 1, 0};

        step(3);
        rst = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_sel", sel, 0);
        chk("rst_hl", highlight, 0);
        chk("rst_start", start_game, 0);
        chk("rst_mode", game_mode, 0);

        for (int i = 0; i < 2; i++) run_vec(i);

        // Enter latency: state changes exactly 6 clk after the raw edge
        set_btn(4'b0100);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk($sformatf("enter_lat_k%0d", k), state, (k < 6) ? 0 : 1);
        end
        step(4);
        set_btn(4'b0000);
        step(12);
        chk("select_hl", highlight, 1);
        chk("select_sel", sel, 0);

        for (int i = 2; i < 8; i++) run_vec(i);

        for (int f = 0; f < 6; f++) begin
            frame();
            chk($sformatf("blink_f%0d", f + 1), highlight, exp_blink[f]);
        end

        press(4'b0100, 10);
        chk("confirm_state", state, 2);
        chk("confirm_hl", highlight, 1);
        frame();
        chk("confirm_t1_hl", highlight, 0);
        chk("confirm_t1_state", state, 2);
        frame();
        chk("confirm_t2_hl", highlight, 1);
        chk("confirm_t2_state", state, 2);
        vsync = 1'b0;
        step(1);
        chk("play_state", state, 3);
        chk("play_start", start_game, 1);
        chk("play_mode", game_mode, 1);
        chk("play_hl", highlight, 0);
        step(1);
        chk("play_start_off", start_game, 0);
        vsync = 1'b1;
        step(18);

        press(4'b1000, 10);
        chk("back_play_state", state, 0);
        chk("back_play_mode", game_mode, 1);
        chk("back_play_hl", highlight, 0);

        press(4'b0100, 10);
        chk("reenter_sel_state", state, 1);
        chk("reenter_sel_sel", sel, 1);
        press(4'b0100, 10);
        chk("reconfirm_state", state, 2);
        frame();
        chk("reconfirm_hl", highlight, 0);
        press(4'b1100, 10);
        chk("abort_state", state, 1);
        chk("abort_sel", sel, 1);
        chk("abort_hl", highlight, 1);
        chk("abort_no_start", start_cnt, 1);

        press(4'b0100, 10);
        chk("confirm3_state", state, 2);
        frame();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_hl", highlight, 0);
        chk("mid_rst_mode", game_mode, 0);
        chk("mid_rst_start", start_game, 0);

        // Press pending in the debouncer is dropped by reset
        set_btn(4'b0100);
        step(3);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        set_btn(4'b0000);
        step(12);
        chk("pending_lost_state", state, 0);

        for (int f = 0; f < 5; f++) frame();
        chk("post_rst_state", state, 0);
        chk("total_start_pulses", start_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
